// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 multiply (radix-2 shift-add) and restoring
// divide on operand magnitudes, sign-corrected once at the end, with the
// results held in HI/LO. MTHI/MTLO write HI/LO directly in one cycle.
// Define MDU_DIV_EN to build the divider in; without it DIV/DIVU are reserved.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO and reserved ops handled here
// CALC   | 32 shift-add / restoring-subtract iterations
// FINISH | sign correction; HI/LO written and done pulsed on exit
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             illegal_op,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t               state, state_nxt;
  logic [5:0]           count;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     b_mag_q;
  logic                 res_neg;
  logic                 launch, mt_write, illegal_nxt, finish_write;
  logic                 is_calc_op, is_mt_op;
  logic                 signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt;
  logic [WIDTH-1:0]     fin_hi, fin_lo;
`ifdef MDU_DIV_EN
  logic                 div_q, rem_neg, div_zero;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH:0]       rem_sh, diff;
  logic [2*WIDTH-1:0]   div_nxt;
`endif

  assign busy         = (state != IDLE);
  assign finish_write = (state == FINISH) && !abort;

  // Op decode and operand magnitudes (even ops are the signed variants)
  always_comb begin
`ifdef MDU_DIV_EN
    is_calc_op = (op[2] == 1'b0);
`else
    is_calc_op = (op[2:1] == 2'b00);
`endif
    is_mt_op  = (op[2:1] == 2'b10);
    signed_op = ~op[0];
    a_neg     = signed_op & operand_a[WIDTH-1];
    b_neg     = signed_op & operand_b[WIDTH-1];
    a_mag     = a_neg ? (~operand_a + 1'b1) : operand_a;
    b_mag     = b_neg ? (~operand_b + 1'b1) : operand_b;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and single-cycle actions; abort beats everything
  always_comb begin
    state_nxt   = state;
    launch      = 1'b0;
    mt_write    = 1'b0;
    illegal_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (is_calc_op) begin
            launch    = 1'b1;
            state_nxt = CALC;
          end else if (is_mt_op) begin
            mt_write = 1'b1;
          end else begin
            illegal_nxt = 1'b1;
          end
        end
      end
      CALC: begin
        if (abort)              state_nxt = IDLE;
        else if (count == 6'd0) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration step of each algorithm
  always_comb begin
    mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, b_mag_q} : '0);
    mul_nxt = {mul_sum, prod[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    rem_sh  = prod[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, b_mag_q};
    div_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                          : {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
`endif
  end

  // Sign correction of the raw magnitude result
  always_comb begin
    fin_hi = prod[2*WIDTH-1:WIDTH];
    fin_lo = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (div_q) begin
      if (div_zero) begin
        fin_hi = a_q;
        fin_lo = '1;
      end else begin
        if (res_neg) fin_lo = ~prod[WIDTH-1:0] + 1'b1;
        if (rem_neg) fin_hi = ~prod[2*WIDTH-1:WIDTH] + 1'b1;
      end
    end else
`endif
    if (res_neg) {fin_hi, fin_lo} = ~prod + 1'b1;
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod    <= '0;
      b_mag_q <= '0;
      res_neg <= 1'b0;
      count   <= 6'd0;
`ifdef MDU_DIV_EN
      div_q    <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      a_q      <= '0;
`endif
    end else if (launch) begin
      prod    <= {{WIDTH{1'b0}}, a_mag};
      b_mag_q <= b_mag;
      res_neg <= a_neg ^ b_neg;
      count   <= 6'd32;
`ifdef MDU_DIV_EN
      div_q    <= op[1];
      rem_neg  <= a_neg;
      div_zero <= (operand_b == '0);
      a_q      <= operand_a;
`endif
    end else if (abort) begin
      count <= 6'd0;
    end else if (state == CALC && count != 6'd0) begin
`ifdef MDU_DIV_EN
      prod <= div_q ? div_nxt : mul_nxt;
`else
      prod <= mul_nxt;
`endif
      count <= count - 6'd1;
    end
  end

  // HI/LO registers and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi         <= '0;
      lo         <= '0;
      done       <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      done       <= 1'b0;
      illegal_op <= illegal_nxt;
      if (finish_write) begin
        hi   <= fin_hi;
        lo   <= fin_lo;
        done <= 1'b1;
      end else if (mt_write) begin
        if (op[0]) lo <= operand_a;
        else       hi <= operand_a;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes expected HI/LO and
// issue cycle for each op that should complete; a monitor pops on done.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, abort, busy, done, illegal_op;
  logic [2:0]  op;
  logic [31:0] operand_a, operand_b, hi, lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .abort(abort),
    .busy(busy), .done(done), .illegal_op(illegal_op), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] save_hi, save_lo;
  logic [2:0]  ill_ops[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done with hi=%h lo=%h, required no done", hi, lo);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_hilo"}, {hi, lo}, {mon_e.hi, mon_e.lo});
        check({mon_e.tag, "_latency"}, 64'(cyc - mon_e.cyc), 64'd34);
      end
    end
  end

  // Present a start for one edge, then scramble operands to prove latching
  task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit expect_done,
                       input logic [31:0] eh, input logic [31:0] el);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; operand_a = 32'h5A5A_A5A5; operand_b = 32'h0F0F_3C3C;
    if (expect_done) sb.push_back('{tag, eh, el, cyc});
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    issue(tag, o, a, b, 1'b1, eh, el);
    repeat (35) @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [2:0] o, input logic [31:0] a, input logic ab);
    op = o; operand_a = a; start = 1'b1; abort = ab;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; op = 3'b000; operand_a = '0; operand_b = '0;
    #12;
    check("reset_flags", {61'd0, busy, done, illegal_op}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Signed multiply with exact busy timing, then back-to-back in the done cycle
    issue("mult_m3x5", 3'b000, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    check("busy_after_e0", {63'd0, busy}, 64'd1);
    repeat (33) @(posedge clk);
    #1;
    check("busy_after_e33", {62'd0, busy, done}, 64'b10);
    @(posedge clk); #1;
    check("busy_in_done_cycle", {62'd0, busy, done}, 64'b01);
    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_7xm6", 3'b000, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
    run_op("mult_minsq", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("multu_8000sq", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("mult_zero", 3'b000, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);

    // MTHI / MTLO
    single(3'b100, 32'hCAFE_BABE, 1'b0);
    check("mthi", {hi, lo}, {32'hCAFE_BABE, 32'd0});
    check("mthi_flags", {61'd0, busy, done, illegal_op}, 64'd0);
    single(3'b101, 32'h1357_9BDF, 1'b0);
    check("mtlo", {hi, lo}, {32'hCAFE_BABE, 32'h1357_9BDF});

    // Start while busy is ignored
    issue("multu_ignored_start", 3'b001, 32'h1234_5678, 32'h0000_0100, 1'b1, 32'h0000_0012, 32'h3456_7800);
    repeat (3) @(posedge clk);
    #1;
    single(3'b100, 32'hDEAD_BEEF, 1'b0);
    check("ignored_start_hi", {hi, 31'd0, busy}, {32'h1357_9BDF ^ 32'h1357_9BDF ^ 32'hCAFE_BABE, 32'd1});
    repeat (31) @(posedge clk);
    #1;

    // Abort during CALC
    save_hi = hi; save_lo = lo;
    issue("abort_calc", 3'b000, 32'd3, 32'd3, 1'b0, 32'd0, 32'd0);
    repeat (9) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_calc_busy", {63'd0, busy}, 64'd0);
    repeat (36) @(posedge clk);
    #1;
    check("abort_calc_hilo", {hi, lo}, {save_hi, save_lo});

    // Abort in FINISH beats the write
    issue("abort_finish", 3'b001, 32'd9, 32'd9, 1'b0, 32'd0, 32'd0);
    repeat (33) @(posedge clk);
    #1;
    check("finish_busy", {63'd0, busy}, 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_finish_busy", {62'd0, busy, done}, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_finish_hilo", {hi, lo}, {save_hi, save_lo});

    // Abort together with start in IDLE drops the start
    single(3'b100, 32'h1111_1111, 1'b1);
    check("abort_idle_mthi", {hi, lo}, {save_hi, save_lo});
    single(3'b000, 32'd2, 1'b1);
    check("abort_idle_mult_busy", {63'd0, busy}, 64'd0);
    repeat (36) @(posedge clk);
    #1;

    // Reserved ops
    ill_ops = '{3'b110, 3'b111};
`ifndef MDU_DIV_EN
    ill_ops.push_back(3'b010);
    ill_ops.push_back(3'b011);
`endif
    foreach (ill_ops[i]) begin
      single(ill_ops[i], 32'h2222_2222, 1'b0);
      check($sformatf("illegal_%b_pulse", ill_ops[i]), {62'd0, illegal_op, busy}, 64'b10);
      check($sformatf("illegal_%b_hilo", ill_ops[i]), {hi, lo}, {save_hi, save_lo});
      @(posedge clk); #1;
      check($sformatf("illegal_%b_clear", ill_ops[i]), {62'd0, illegal_op, busy}, 64'b00);
    end

`ifdef MDU_DIV_EN
    run_op("div_m7by2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_by0", 3'b011, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div_m5by0", 3'b010, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div_100bym7", 3'b010, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);
    run_op("divu_max_by10", 3'b011, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999);
    issue("rst_mid", 3'b011, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0);
`else
    issue("rst_mid", 3'b001, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0);
`endif

    // Reset mid-operation, then a clean op afterwards
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_flags", {61'd0, busy, done, illegal_op}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("mult_after_rst", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

●

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/HI/LO width; only 32 is supported.
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  in  1  one-cycle op request, sampled only when busy=0.
REQ-005 SHALL have port: op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-006 SHALL have port: operand_a  in  32  [rs]: multiplicand, dividend, or MTHI/MTLO source.
REQ-007 SHALL have port: operand_b  in  32  [rt]: multiplier or divisor.
REQ-008 SHALL have port: abort  in  1  pipeline flush; cancels any in-flight op.
REQ-009 SHALL have port: busy  out  1  iterative op in flight.
REQ-010 SHALL have port: done  out  1  one-cycle pulse; HI/LO updated in the same cycle.
REQ-011 SHALL have port: illegal_op  out  1  one-cycle pulse on an unsupported op.
REQ-012 SHALL have port: hi  out  32  HI register.
REQ-013 SHALL have port: lo  out  32  LO register.

Function
REQ-014 SHALL use FSM states IDLE, CALC, FINISH.
- IDLE->CALC on start with op 000-011.
- CALC->FINISH after exactly 32 iterations.
- FINISH->IDLE unconditionally.
REQ-015 SHALL latch operands at the start edge; later operand changes have no effect.
REQ-016 SHALL multiply with radix-2 shift-add on magnitudes (signed ops take absolute values) and produce a 64-bit product: {HI,LO}.
REQ-017 SHALL divide with restoring division on magnitudes: LO=quotient, HI=remainder.
REQ-018 SHALL apply sign correction in FINISH:
- quotient negative iff operand signs differ;
- remainder takes the dividend's sign;
- product negative iff operand signs differ.
REQ-019 SHALL write HI/LO and pulse done on the FINISH->IDLE edge: start at edge E0 gives done=1 and new hi/lo after edge E34 (34-cycle latency).
REQ-020 SHALL drive busy=1 after E0 through edge E33 and busy=0 in the done cycle; a new start is accepted in the done cycle.
REQ-021 SHALL ignore start while busy=1: no state, HI/LO or flag change.
REQ-022 SHALL handle divide-by-zero (DIV/DIVU): LO=32'hFFFF_FFFF, HI=operand_a, normal 34-cycle latency.
REQ-023 SHALL handle DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
REQ-024 SHALL execute MTHI/MTLO from IDLE in one edge: HI (or LO) = operand_a, no busy, no done.
REQ-025 SHALL pulse illegal_op for op 110/111 when start=1 and busy=0, with no other effect.
REQ-026 SHALL handle abort:
- abort=1 in CALC or FINISH returns to IDLE on the next edge;
- no done pulse, HI/LO unchanged;
- abort takes priority over the FINISH write.
REQ-027 SHALL give abort priority when abort and start occur together in IDLE: start is dropped.

Reset
REQ-028 SHALL on rst=1, asynchronously: state=IDLE, busy=0, done=0, illegal_op=0, hi=0, lo=0, iteration counter=0.
REQ-029 SHALL treat reset mid-operation as an abort with HI/LO cleared; the first start after rst deasserts behaves as from power-up.

Configuration
REQ-030 SHALL use macro MDU_DIV_EN to compile the divider in or out:
- defined: DIV/DIVU supported as above;
- undefined: no divider logic; DIV/DIVU are treated as reserved ops (illegal_op pulse, no busy, HI/LO unchanged); MULT/MULTU latency is unchanged.

Verification
REQ-031 SHALL cover signed multiply: MULT a=32'hFFFF_FFFD (-3), b=5 -> done after exactly 34 cycles, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFF1.
REQ-032 SHALL cover unsigned multiply: MULTU a=b=32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001.
REQ-033 SHALL cover signed divide and its corners:
- DIV a=-7 (32'hFFFF_FFF9), b=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF;
- DIV 32'h8000_0000 / -1 -> LO=32'h8000_0000, HI=0.
REQ-034 SHALL cover divide-by-zero: DIVU a=7, b=0 -> LO=32'hFFFF_FFFF, HI=7, done at cycle 34.
REQ-035 SHALL cover abort and ignored start: MULT issued, abort at cycle 10 -> busy=0 next cycle, no done, HI/LO unchanged; a start issued at cycle 5 of a running op is ignored.
REQ-036 SHALL cover reset mid-op: rst asserted at cycle 20 of DIVU -> all outputs 0 immediately; with MDU_DIV_EN undefined, a DIV start -> illegal_op=1 for one cycle, busy stays 0.
